// File: rtl/edge_det_pkg.sv
// Shared types and helpers for the edge detector bank.
// Mode encoding: bit0 enables rising edges, bit1 enables falling edges.
package edge_det_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_OFF  = 2'b00;
    localparam mode_t MODE_RISE = 2'b01;
    localparam mode_t MODE_FALL = 2'b10;
    localparam mode_t MODE_BOTH = 2'b11;

    // Width of the debounce stability counter; never narrower than one bit.
    function automatic int stab_width(input int debounce);
        return (debounce <= 1) ? 1 : $clog2(debounce);
    endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One channel: synchronizer, debounce filter, edge qualification,
// sticky flag and saturating event counter.
module edge_det_channel
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  mode_t            mode,
    input  logic             clr,
    output logic             level,
    output logic             edge_pulse,
    output logic             event_flag,
    output logic [CNT_W-1:0] event_cnt
);

    localparam int             SW       = stab_width(DEBOUNCE);
    localparam logic [SW-1:0]  STAB_MAX = SW'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [SW-1:0]          stab_q, stab_d;
    logic                   level_q, level_d;
    logic                   pulse_q, pulse_d;
    logic                   flag_q, flag_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic s;
    logic commit;
    logic rise_en;
    logic fall_en;
    logic qual;

    assign s       = sync_q[SYNC_STAGES-1];
    assign rise_en = (mode == MODE_RISE) || (mode == MODE_BOTH);
    assign fall_en = (mode == MODE_FALL) || (mode == MODE_BOTH);

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din};
        stab_d  = stab_q;
        level_d = level_q;
        commit  = 1'b0;

        if (s == level_q) begin
            stab_d = '0;
        end else if (stab_q == STAB_MAX) begin
            commit  = 1'b1;
            level_d = s;
            stab_d  = '0;
        end else begin
            stab_d = stab_q + SW'(1);
        end

        // Mode is looked at only on the committing edge itself.
        qual    = commit && (s ? rise_en : fall_en);
        pulse_d = qual;

        flag_d = flag_q;
        cnt_d  = cnt_q;
        if (clr) begin
            flag_d = 1'b0;
            cnt_d  = '0;
        end
        // A coincident edge wins over clr so the event is never lost.
        if (qual) begin
            flag_d = 1'b1;
            if (clr) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            stab_q  <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            flag_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            stab_q  <= stab_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level      = level_q;
    assign edge_pulse = pulse_q;
    assign event_flag = flag_q;
    assign event_cnt  = cnt_q;

endmodule

// File: rtl/edge_detector_bank.sv
// Bank of independent debounced edge detectors for raw asynchronous pins.
// Each channel has its own 2-bit mode slice and CNT_W-bit counter slice.
module edge_detector_bank
    import edge_det_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       din,
    input  logic [2*N_CH-1:0]     mode,
    input  logic [N_CH-1:0]       clr,
    output logic [N_CH-1:0]       level,
    output logic [N_CH-1:0]       edge_pulse,
    output logic [N_CH-1:0]       event_flag,
    output logic [N_CH*CNT_W-1:0] event_cnt
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        mode_t ch_mode;
        assign ch_mode = mode[2*i +: 2];

        edge_det_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE    (DEBOUNCE),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .din        (din[i]),
            .mode       (ch_mode),
            .clr        (clr[i]),
            .level      (level[i]),
            .edge_pulse (edge_pulse[i]),
            .event_flag (event_flag[i]),
            .event_cnt  (event_cnt[CNT_W*i +: CNT_W])
        );
    end

endmodule

// File: tb/tb_edge_detector_bank.sv
// Scoreboard bench for edge_detector_bank: a sample-history reference model
// predicts every cycle's outputs, a monitor pops and compares after each edge.
module tb_edge_detector_bank;
    import edge_det_pkg::*;

    localparam int N_CH  = 4;
    localparam int SYNC  = 2;
    localparam int DEB   = 4;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [N_CH-1:0]       level;
        logic [N_CH-1:0]       pulse;
        logic [N_CH-1:0]       flag;
        logic [N_CH*CNT_W-1:0] cnt;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_CH-1:0]       din;
    logic [2*N_CH-1:0]     mode;
    logic [N_CH-1:0]       clr;
    logic [N_CH-1:0]       level;
    logic [N_CH-1:0]       edge_pulse;
    logic [N_CH-1:0]       event_flag;
    logic [N_CH*CNT_W-1:0] event_cnt;

    int n_vec = 0;
    int n_bad = 0;

    exp_t sb[$];

    bit dh[N_CH][$];
    bit m_level[N_CH];
    bit m_pulse[N_CH];
    bit m_flag[N_CH];
    int m_cnt[N_CH];

    edge_detector_bank #(
        .N_CH        (N_CH),
        .SYNC_STAGES (SYNC),
        .DEBOUNCE    (DEB),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .mode       (mode),
        .clr        (clr),
        .level      (level),
        .edge_pulse (edge_pulse),
        .event_flag (event_flag),
        .event_cnt  (event_cnt)
    );

    always #5 clk = ~clk;

    function automatic exp_t pack_model();
        exp_t e;
        for (int ch = 0; ch < N_CH; ch++) begin
            e.level[ch] = m_level[ch];
            e.pulse[ch] = m_pulse[ch];
            e.flag[ch]  = m_flag[ch];
            e.cnt[CNT_W*ch +: CNT_W] = CNT_W'(m_cnt[ch]);
        end
        return e;
    endfunction

    task automatic model_reset();
        for (int ch = 0; ch < N_CH; ch++) begin
            dh[ch].delete();
            m_level[ch] = 0;
            m_pulse[ch] = 0;
            m_flag[ch]  = 0;
            m_cnt[ch]   = 0;
        end
    endtask

    // Level accepts the synchronized input once it has disagreed with the
    // current level for DEB consecutive samples, seen SYNC samples late.
    task automatic model_edge();
        for (int ch = 0; ch < N_CH; ch++) begin
            int       sz;
            bit       commit;
            bit       qual;
            bit [1:0] md;
            sz     = dh[ch].size();
            commit = 1;
            qual   = 0;
            md     = mode[2*ch +: 2];
            for (int j = 0; j < DEB; j++) begin
                int idx;
                bit sv;
                idx = sz - SYNC - j;
                sv  = (idx >= 0) ? dh[ch][idx] : 1'b0;
                if (sv == m_level[ch]) commit = 0;
            end
            if (commit) begin
                m_level[ch] = ~m_level[ch];
                qual = m_level[ch] ? md[0] : md[1];
            end
            m_pulse[ch] = qual;
            if (clr[ch]) begin
                m_flag[ch] = 0;
                m_cnt[ch]  = 0;
            end
            if (qual) begin
                m_flag[ch] = 1;
                m_cnt[ch]  = clr[ch] ? 1 : ((m_cnt[ch] < CMAX) ? m_cnt[ch] + 1 : m_cnt[ch]);
            end
            dh[ch].push_back(din[ch]);
            if (dh[ch].size() > SYNC + DEB + 1) void'(dh[ch].pop_front());
        end
    endtask

    task automatic step();
        model_edge();
        sb.push_back(pack_model());
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        model_reset();
        repeat (n) begin
            sb.push_back(pack_model());
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int dut_cnt(input int ch);
        return int'(event_cnt[CNT_W*ch +: CNT_W]);
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL sb_empty at %0t: no expected entry queued", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_vec++;
                if (level !== e.level) begin
                    n_bad++;
                    $display("FAIL level @%0t: got %b expected %b", $time, level, e.level);
                end
                if (edge_pulse !== e.pulse) begin
                    n_bad++;
                    $display("FAIL edge_pulse @%0t: got %b expected %b", $time, edge_pulse, e.pulse);
                end
                if (event_flag !== e.flag) begin
                    n_bad++;
                    $display("FAIL event_flag @%0t: got %b expected %b", $time, event_flag, e.flag);
                end
                if (event_cnt !== e.cnt) begin
                    n_bad++;
                    $display("FAIL event_cnt @%0t: got %h expected %h", $time, event_cnt, e.cnt);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst  = 1'b1;
        din  = '0;
        clr  = '0;
        mode = {N_CH{MODE_RISE}};
        do_reset(3);

        // Single rise on channel 0: visible on the 6th edge after the change.
        din[0] = 1'b1;
        repeat (5) step();
        chk("lat_level0_early", level[0], 0);
        step();
        chk("lat_level0", level[0], 1);
        chk("lat_pulse0", edge_pulse[0], 1);
        step();
        chk("lat_pulse0_width", edge_pulse[0], 0);
        repeat (6) step();
        chk("s1_flag0", event_flag[0], 1);
        chk("s1_cnt0", dut_cnt(0), 1);
        chk("s1_cnt1", dut_cnt(1), 0);

        // Glitch shorter than DEB, then exactly DEB cycles.
        din[1] = 1'b1;
        repeat (3) step();
        din[1] = 1'b0;
        repeat (10) step();
        chk("glitch_level1", level[1], 0);
        chk("glitch_cnt1", dut_cnt(1), 0);
        din[1] = 1'b1;
        repeat (4) step();
        din[1] = 1'b0;
        repeat (12) step();
        chk("deb4_cnt1", dut_cnt(1), 1);

        // Both-edge mode, then off mode, on channel 2.
        mode[5:4] = MODE_BOTH;
        repeat (5) begin
            din[2] = ~din[2];
            repeat (10) step();
        end
        chk("both_cnt2", dut_cnt(2), 5);
        clr[2] = 1'b1;
        step();
        clr[2] = 1'b0;
        chk("clr_cnt2", dut_cnt(2), 0);
        chk("clr_flag2", event_flag[2], 0);
        mode[5:4] = MODE_OFF;
        repeat (5) begin
            din[2] = ~din[2];
            repeat (10) step();
        end
        chk("off_cnt2", dut_cnt(2), 0);
        chk("off_level2", level[2], 0);

        // Saturation on channel 3.
        repeat (9) begin
            din[3] = 1'b1;
            repeat (6) step();
            din[3] = 1'b0;
            repeat (6) step();
        end
        chk("sat_cnt3", dut_cnt(3), CMAX);
        clr[3] = 1'b1;
        step();
        clr[3] = 1'b0;
        chk("sat_clr_cnt3", dut_cnt(3), 0);
        chk("sat_clr_flag3", event_flag[3], 0);

        // clr lands on the same edge as a qualified rise.
        din[3] = 1'b1;
        repeat (5) step();
        clr[3] = 1'b1;
        step();
        clr[3] = 1'b0;
        chk("coinc_pulse3", edge_pulse[3], 1);
        chk("coinc_flag3", event_flag[3], 1);
        chk("coinc_cnt3", dut_cnt(3), 1);

        // Reset in the middle of a debounce, din held high through release.
        din[1] = 1'b1;
        repeat (2) step();
        do_reset(2);
        repeat (5) step();
        chk("rst_pulse1_early", edge_pulse[1], 0);
        step();
        chk("rst_pulse1", edge_pulse[1], 1);
        chk("rst_cnt1", dut_cnt(1), 1);
        repeat (4) step();

        // Randomized traffic.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if ($urandom_range(11) == 0) din[ch] = ~din[ch];
                if ($urandom_range(49) == 0) mode[2*ch +: 2] = 2'($urandom_range(3));
                clr[ch] = ($urandom_range(39) == 0);
            end
            if ($urandom_range(399) == 0) begin
                clr = '0;
                do_reset(1 + $urandom_range(1));
            end else begin
                step();
            end
        end
        clr = '0;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
